gen_reg_bank: RTL and testbench
===============================

GEN_REG_BANK -- requirements
Module: gen_reg_bank

Interface
REQ-001 SHALL have parameter PA_DATA_WIDTH, default 32, register and PC width in bits.
REQ-002 SHALL have parameter PA_PC_RESET, default 32'h0, PC value loaded on reset.
REQ-003 SHALL have parameter PA_PC_STEP, default 4, PC increment amount.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_b  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wa_req  input  1  write port A request; held high until wa_ack is seen.
REQ-007 SHALL have port wa_addr  input  4  write port A target register index 0-15.
REQ-008 SHALL have port wa_data  input  PA_DATA_WIDTH  write port A data.
REQ-009 SHALL have port wa_ack  output  1  one-cycle pulse confirming the port A write.
REQ-010 SHALL have ports wb_req, wb_addr, wb_data, wb_ack with the same widths and meanings for write port B.
REQ-011 SHALL have port pc_load  input  1  load PC from pc_load_val.
REQ-012 SHALL have port pc_load_val  input  PA_DATA_WIDTH  branch target.
REQ-013 SHALL have port pc_inc  input  1  advance PC by PA_PC_STEP.
REQ-014 SHALL have ports reg0..reg15  output  PA_DATA_WIDTH each  registered contents, feeding the 17:1 operand mux inputs.
REQ-015 SHALL have port pc  output  PA_DATA_WIDTH  registered PC, feeding the operand mux pc input.

Function
REQ-016 Each write port SHALL run a two-state FSM: IDLE, ACK.
REQ-017 In IDLE with req high and grant, the port SHALL write data to reg[addr] at that edge and enter ACK; ack is high for exactly the next cycle.
REQ-018 In ACK the port SHALL ignore req, drive ack high, and return to IDLE on the next edge; back-to-back writes from one port are therefore spaced at least two cycles apart.
REQ-019 Port A SHALL always be granted in IDLE.
REQ-020 Port B SHALL be granted unless port A is granted in the same cycle with wa_addr == wb_addr; a denied port B stays IDLE, ack low, and retries on the following cycle.
REQ-021 Simultaneous grants to different addresses SHALL both commit in the same edge.
REQ-022 Register contents SHALL appear on reg0..reg15 the cycle after the commit edge (no write-through bypass).
REQ-023 pc_load SHALL take priority over pc_inc; with both high, pc = pc_load_val next cycle.
REQ-024 pc_inc alone SHALL set pc = pc + PA_PC_STEP modulo 2^PA_DATA_WIDTH (silent wrap, no flag).
REQ-025 With neither pc_load nor pc_inc high, pc SHALL hold.
REQ-026 PC updates SHALL be independent of the write ports; write ports cannot target pc.

Reset
REQ-027 When rst_b is high at an edge, reg0..reg15 SHALL become 0, pc SHALL become PA_PC_RESET, both FSMs SHALL enter IDLE, and wa_ack/wb_ack SHALL be 0 the next cycle.
REQ-028 Reset SHALL override any concurrent write, PC load or increment; a write in flight or a denied port B retry is discarded without ack.
REQ-029 Requests held high through reset SHALL be serviced normally from the first cycle after rst_b falls.

Verification
REQ-030 Reset: assert rst_b 1 cycle with wa_req=1, pc_inc=1 -> all reg outputs 0, pc=0, no ack pulse.
REQ-031 Single write: wa_req=1, wa_addr=5, wa_data=32'h55555555 -> wa_ack high the next cycle, reg5=32'h55555555, other registers unchanged.
REQ-032 Collision: wa and wb both to addr 3, data 32'hAAAAAAAA / 32'hBBBBBBBB, both held until ack -> wa_ack at cycle 1, wb_ack at cycle 2, final reg3=32'hBBBBBBBB.
REQ-033 Parallel writes: wa to addr 1 = 32'h11111111 and wb to addr 15 = 32'hFFFFFFFF in the same cycle -> both acks in the same cycle, both registers updated.
REQ-034 PC: pc_inc from 32'hFFFFFFFC -> 32'h0; pc_load=1 and pc_inc=1 with pc_load_val=32'hABABABAB -> pc=32'hABABABAB.
REQ-035 Held request: wa_req held high for 4 cycles to addr 2 -> exactly two writes, acks on cycles 1 and 3, never on consecutive cycles.

Source files
------------

// File: rtl/gen_reg_bank.sv
// Sixteen-entry register bank with two handshaked write ports (A has priority on
// same-address collisions) and a program counter with load/increment.
//
// State of each write port FSM:
//   state   | meaning
//   WP_IDLE | ready; commits a granted request at the next edge
//   WP_ACK  | write committed last edge; ack high, request ignored
module gen_reg_bank #(
   parameter int unsigned              PA_DATA_WIDTH = 32,
   parameter logic [PA_DATA_WIDTH-1:0] PA_PC_RESET   = '0,
   parameter int unsigned              PA_PC_STEP    = 4
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic                     wa_req,
   input  logic [3:0]               wa_addr,
   input  logic [PA_DATA_WIDTH-1:0] wa_data,
   output logic                     wa_ack,
   input  logic                     wb_req,
   input  logic [3:0]               wb_addr,
   input  logic [PA_DATA_WIDTH-1:0] wb_data,
   output logic                     wb_ack,
   input  logic                     pc_load,
   input  logic [PA_DATA_WIDTH-1:0] pc_load_val,
   input  logic                     pc_inc,
   output logic [PA_DATA_WIDTH-1:0] reg0,
   output logic [PA_DATA_WIDTH-1:0] reg1,
   output logic [PA_DATA_WIDTH-1:0] reg2,
   output logic [PA_DATA_WIDTH-1:0] reg3,
   output logic [PA_DATA_WIDTH-1:0] reg4,
   output logic [PA_DATA_WIDTH-1:0] reg5,
   output logic [PA_DATA_WIDTH-1:0] reg6,
   output logic [PA_DATA_WIDTH-1:0] reg7,
   output logic [PA_DATA_WIDTH-1:0] reg8,
   output logic [PA_DATA_WIDTH-1:0] reg9,
   output logic [PA_DATA_WIDTH-1:0] reg10,
   output logic [PA_DATA_WIDTH-1:0] reg11,
   output logic [PA_DATA_WIDTH-1:0] reg12,
   output logic [PA_DATA_WIDTH-1:0] reg13,
   output logic [PA_DATA_WIDTH-1:0] reg14,
   output logic [PA_DATA_WIDTH-1:0] reg15,
   output logic [PA_DATA_WIDTH-1:0] pc
);

   typedef enum logic {
      WP_IDLE = 1'b0,
      WP_ACK  = 1'b1
   } wp_state_e;

   wp_state_e                 wa_state_q, wa_state_d;
   wp_state_e                 wb_state_q, wb_state_d;
   logic                      wa_grant, wb_grant;
   logic [PA_DATA_WIDTH-1:0]  rf_q [16];
   logic [PA_DATA_WIDTH-1:0]  rf_d [16];
   logic [PA_DATA_WIDTH-1:0]  pc_q, pc_d;

   always_comb begin
      wa_grant   = 1'b0;
      wb_grant   = 1'b0;
      wa_state_d = WP_IDLE;
      wb_state_d = WP_IDLE;
      wa_grant = (wa_state_q == WP_IDLE) && wa_req;
      // B yields only when A commits to the same register this edge.
      wb_grant = (wb_state_q == WP_IDLE) && wb_req &&
                 !(wa_grant && (wa_addr == wb_addr));
      if (wa_grant) wa_state_d = WP_ACK;
      if (wb_grant) wb_state_d = WP_ACK;
   end

   always_comb begin
      rf_d = rf_q;
      if (wa_grant) rf_d[wa_addr] = wa_data;
      if (wb_grant) rf_d[wb_addr] = wb_data;
   end

   always_comb begin
      pc_d = pc_q;
      if (pc_load)     pc_d = pc_load_val;
      else if (pc_inc) pc_d = pc_q + PA_DATA_WIDTH'(PA_PC_STEP);
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         wa_state_q <= WP_IDLE;
         wb_state_q <= WP_IDLE;
         rf_q       <= '{default: '0};
         pc_q       <= PA_PC_RESET;
      end else begin
         wa_state_q <= wa_state_d;
         wb_state_q <= wb_state_d;
         rf_q       <= rf_d;
         pc_q       <= pc_d;
      end
   end

   assign wa_ack = (wa_state_q == WP_ACK);
   assign wb_ack = (wb_state_q == WP_ACK);
   assign pc     = pc_q;

   assign reg0  = rf_q[0];
   assign reg1  = rf_q[1];
   assign reg2  = rf_q[2];
   assign reg3  = rf_q[3];
   assign reg4  = rf_q[4];
   assign reg5  = rf_q[5];
   assign reg6  = rf_q[6];
   assign reg7  = rf_q[7];
   assign reg8  = rf_q[8];
   assign reg9  = rf_q[9];
   assign reg10 = rf_q[10];
   assign reg11 = rf_q[11];
   assign reg12 = rf_q[12];
   assign reg13 = rf_q[13];
   assign reg14 = rf_q[14];
   assign reg15 = rf_q[15];

endmodule

// File: tb/tb_gen_reg_bank.sv
// Directed vector table followed by randomized traffic checked against a
// behavioural model of the register bank and PC.
module tb_gen_reg_bank;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        wa_req, wb_req, pc_load, pc_inc;
   logic [3:0]  wa_addr, wb_addr;
   logic [31:0] wa_data, wb_data, pc_load_val;
   logic        wa_ack, wb_ack;
   logic [31:0] pc;
   logic [31:0] r [16];

   always #5 clk = ~clk;

   gen_reg_bank dut (
      .clk(clk), .rst_b(rst_b),
      .wa_req(wa_req), .wa_addr(wa_addr), .wa_data(wa_data), .wa_ack(wa_ack),
      .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
      .pc_load(pc_load), .pc_load_val(pc_load_val), .pc_inc(pc_inc),
      .reg0(r[0]), .reg1(r[1]), .reg2(r[2]), .reg3(r[3]),
      .reg4(r[4]), .reg5(r[5]), .reg6(r[6]), .reg7(r[7]),
      .reg8(r[8]), .reg9(r[9]), .reg10(r[10]), .reg11(r[11]),
      .reg12(r[12]), .reg13(r[13]), .reg14(r[14]), .reg15(r[15]),
      .pc(pc)
   );

   typedef struct {
      logic        rst;
      logic        wa_req; logic [3:0] wa_addr; logic [31:0] wa_data;
      logic        wb_req; logic [3:0] wb_addr; logic [31:0] wb_data;
      logic        pc_load; logic [31:0] pc_val; logic pc_inc;
      logic        e_wa_ack; logic e_wb_ack;
      logic [3:0]  c_addr; logic [31:0] e_reg; logic [31:0] e_pc;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: register file contents, PC, and whether each port
   // committed a write on the last edge (so it owes an ack and is busy).
   logic [31:0] m_reg [16];
   logic [31:0] m_pc;
   logic        m_a_busy, m_b_busy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic a_go, b_go;
      if (rst_b) begin
         for (int i = 0; i < 16; i++) m_reg[i] = '0;
         m_pc     = 32'h0;
         m_a_busy = 1'b0;
         m_b_busy = 1'b0;
      end else begin
         a_go = wa_req && !m_a_busy;
         b_go = wb_req && !m_b_busy && !(a_go && wa_addr == wb_addr);
         if (a_go) m_reg[wa_addr] = wa_data;
         if (b_go) m_reg[wb_addr] = wb_data;
         m_a_busy = a_go;
         m_b_busy = b_go;
         if (pc_load)     m_pc = pc_load_val;
         else if (pc_inc) m_pc = m_pc + 32'd4;
      end
   endtask

   // Drive at negedge, advance the model, sample 1 time unit after the edge.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   vec_t vt [24];

   initial begin
      rst_b = 1'b1; wa_req = 0; wb_req = 0; pc_load = 0; pc_inc = 0;
      wa_addr = 0; wb_addr = 0; wa_data = 0; wb_data = 0; pc_load_val = 0;
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      m_pc = 0; m_a_busy = 0; m_b_busy = 0;

      //        rst wa a  data         wb a   data         ld val          inc eA eB ca  reg          pc
      vt[0]  = '{1, 1, 0, 32'h00000001, 0, 0,  32'h0,        0, 32'h0,        1, 0, 0, 0,  32'h0,        32'h0};
      vt[1]  = '{0, 1, 5, 32'h55555555, 0, 0,  32'h0,        0, 32'h0,        0, 1, 0, 5,  32'h55555555, 32'h0};
      vt[2]  = '{0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 32'h0,        0, 0, 0, 4,  32'h0,        32'h0};
      vt[3]  = '{0, 1, 3, 32'hAAAAAAAA, 1, 3,  32'hBBBBBBBB, 0, 32'h0,        0, 1, 0, 3,  32'hAAAAAAAA, 32'h0};
      vt[4]  = '{0, 0, 0, 32'h0,        1, 3,  32'hBBBBBBBB, 0, 32'h0,        0, 0, 1, 3,  32'hBBBBBBBB, 32'h0};
      vt[5]  = '{0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 32'h0,        0, 0, 0, 3,  32'hBBBBBBBB, 32'h0};
      vt[6]  = '{0, 1, 1, 32'h11111111, 1, 15, 32'hFFFFFFFF, 0, 32'h0,        0, 1, 1, 1,  32'h11111111, 32'h0};
      vt[7]  = '{0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 32'h0,        0, 0, 0, 15, 32'hFFFFFFFF, 32'h0};
      vt[8]  = '{0, 0, 0, 32'h0,        0, 0,  32'h0,        1, 32'hFFFFFFFC, 0, 0, 0, 5,  32'h55555555, 32'hFFFFFFFC};
      vt[9]  = '{0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 32'h0,        1, 0, 0, 1,  32'h11111111, 32'h0};
      vt[10] = '{0, 0, 0, 32'h0,        0, 0,  32'h0,        1, 32'hABABABAB, 1, 0, 0, 3,  32'hBBBBBBBB, 32'hABABABAB};
      vt[11] = '{0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 32'h0,        0, 0, 0, 15, 32'hFFFFFFFF, 32'hABABABAB};
      vt[12] = '{0, 1, 2, 32'h22222222, 0, 0,  32'h0,        0, 32'h0,        0, 1, 0, 2,  32'h22222222, 32'hABABABAB};
      vt[13] = '{0, 1, 2, 32'h33333333, 0, 0,  32'h0,        0, 32'h0,        0, 0, 0, 2,  32'h22222222, 32'hABABABAB};
      vt[14] = '{0, 1, 2, 32'h44444444, 0, 0,  32'h0,        0, 32'h0,        0, 1, 0, 2,  32'h44444444, 32'hABABABAB};
      vt[15] = '{0, 1, 2, 32'h55555555, 0, 0,  32'h0,        0, 32'h0,        0, 0, 0, 2,  32'h44444444, 32'hABABABAB};
      vt[16] = '{0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 32'h0,        0, 0, 0, 2,  32'h44444444, 32'hABABABAB};
      vt[17] = '{0, 1, 7, 32'h77777777, 0, 0,  32'h0,        0, 32'h0,        1, 1, 0, 7,  32'h77777777, 32'hABABABAF};
      vt[18] = '{1, 1, 7, 32'h99999999, 1, 8,  32'h88888888, 1, 32'h12345678, 1, 0, 0, 7,  32'h0,        32'h0};
      vt[19] = '{0, 0, 0, 32'h0,        1, 8,  32'h88888888, 0, 32'h0,        0, 0, 1, 8,  32'h88888888, 32'h0};
      vt[20] = '{0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 32'h0,        0, 0, 0, 8,  32'h88888888, 32'h0};
      vt[21] = '{0, 1, 6, 32'h66666666, 1, 6,  32'hE6E6E6E6, 0, 32'h0,        0, 1, 0, 6,  32'h66666666, 32'h0};
      vt[22] = '{1, 0, 0, 32'h0,        1, 6,  32'hE6E6E6E6, 0, 32'h0,        0, 0, 0, 6,  32'h0,        32'h0};
      vt[23] = '{0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 32'h0,        0, 0, 0, 6,  32'h0,        32'h0};

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         rst_b = vt[i].rst;
         wa_req = vt[i].wa_req; wa_addr = vt[i].wa_addr; wa_data = vt[i].wa_data;
         wb_req = vt[i].wb_req; wb_addr = vt[i].wb_addr; wb_data = vt[i].wb_data;
         pc_load = vt[i].pc_load; pc_load_val = vt[i].pc_val; pc_inc = vt[i].pc_inc;
         cycle();
         chk($sformatf("vec%0d wa_ack", i), {31'b0, wa_ack}, {31'b0, vt[i].e_wa_ack});
         chk($sformatf("vec%0d wb_ack", i), {31'b0, wb_ack}, {31'b0, vt[i].e_wb_ack});
         chk($sformatf("vec%0d reg%0d", i, vt[i].c_addr), r[vt[i].c_addr], vt[i].e_reg);
         chk($sformatf("vec%0d pc", i), pc, vt[i].e_pc);
         if (vt[i].rst)
            for (int k = 0; k < 16; k++) chk($sformatf("vec%0d rst reg%0d", i, k), r[k], 32'h0);
      end

      // Random traffic on a narrow address range to provoke collisions.
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         rst_b       = ($urandom_range(0, 59) == 0);
         wa_req      = $urandom_range(0, 2) != 0;
         wb_req      = $urandom_range(0, 2) != 0;
         wa_addr     = 4'($urandom_range(0, 3));
         wb_addr     = 4'($urandom_range(0, 3));
         wa_data     = $urandom;
         wb_data     = $urandom;
         pc_load     = ($urandom_range(0, 7) == 0);
         pc_load_val = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : $urandom;
         pc_inc      = $urandom_range(0, 1) == 1;
         cycle();
         chk($sformatf("rnd%0d wa_ack", c), {31'b0, wa_ack}, {31'b0, m_a_busy});
         chk($sformatf("rnd%0d wb_ack", c), {31'b0, wb_ack}, {31'b0, m_b_busy});
         chk($sformatf("rnd%0d pc", c), pc, m_pc);
         for (int k = 0; k < 16; k++) chk($sformatf("rnd%0d reg%0d", c, k), r[k], m_reg[k]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
